// File: rtl/mem_wb_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_reg
//   MEM/WB pipeline register. It captures the MEM-stage results for the
//   write-back stage. It also tracks a sticky HALT flag and a saturating count
//   of retired instructions.
//
// Slot qualification:
//   i_valid marks a real instruction in the MEM slot. It is sampled only on an
//   advance edge. There is no back-pressure.
//   o_valid marks a real instruction in the WB slot.
//   o_regwrite is already qualified by o_valid and by rd != 0, so the register
//   file can use it directly as its write enable.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous active-low reset
//   i_enable     run/step enable from the debug unit
//   i_stall      hold the current contents
//   i_flush      squash the current contents (needs i_enable)
//   i_valid      MEM slot holds a real instruction
//   i_address    ALU result / memory address      -> o_address
//   i_dataread   data-memory read word            -> o_dataread
//   i_memtoreg   WB select flag                   -> o_memtoreg
//   i_regwrite   instruction writes the reg file  -> o_regwrite (qualified)
//   i_rd         destination register index       -> o_rd
//   i_halt       instruction is HALT              -> o_halt (sticky)
//   o_valid      WB slot valid
//   o_retired    saturating retired-instruction count
// -----------------------------------------------------------------------------
module mem_wb_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic [DATA_WIDTH-1:0]     i_address,
  input  logic [DATA_WIDTH-1:0]     i_dataread,
  input  logic                      i_memtoreg,
  input  logic                      i_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd,
  input  logic                      i_halt,
  output logic [DATA_WIDTH-1:0]     o_address,
  output logic [DATA_WIDTH-1:0]     o_dataread,
  output logic                      o_memtoreg,
  output logic                      o_regwrite,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
  output logic                      o_valid,
  output logic                      o_halt,
  output logic [DATA_WIDTH-1:0]     o_retired
);

  localparam logic [DATA_WIDTH-1:0] RETIRED_MAX = '1;

  logic flush_hit;
  logic advance;

  // A flush only takes effect while the pipeline is enabled. It overrides
  // both the stall and the halted state.
  assign flush_hit = i_enable & i_flush;
  assign advance   = i_enable & ~i_stall & ~o_halt & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_address  <= '0;
      o_dataread <= '0;
      o_memtoreg <= 1'b0;
      o_regwrite <= 1'b0;
      o_rd       <= '0;
      o_valid    <= 1'b0;
      o_halt     <= 1'b0;
      o_retired  <= '0;
    end else if (flush_hit) begin
      // Squash the slot. The address, data and rd fields keep their values,
      // and the count and the halt flag are not changed.
      o_valid    <= 1'b0;
      o_regwrite <= 1'b0;
      o_memtoreg <= 1'b0;
    end else if (o_halt) begin
      // Frozen after HALT. The HALT's own write happens once, on the cycle
      // it is captured, and is never repeated.
      o_regwrite <= 1'b0;
    end else if (advance) begin
      o_address  <= i_address;
      o_dataread <= i_dataread;
      o_memtoreg <= i_memtoreg;
      o_rd       <= i_rd;
      o_valid    <= i_valid;
      // r0 is hard-wired to zero, so a write to it is dropped here.
      o_regwrite <= i_regwrite & i_valid & (i_rd != '0);
      if (i_valid && i_halt) begin
        o_halt <= 1'b1;
      end
      if (i_valid && (o_retired != RETIRED_MAX)) begin
        o_retired <= o_retired + DATA_WIDTH'(1);
      end
    end
    // The remaining case is a stall or disabled cycle: everything holds.
  end

endmodule

// File: tb/tb_mem_wb_reg.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_reg
//   Directed and random stimulus for mem_wb_reg. A behavioural model of the
//   WB slot is kept in the bench.
//   A second instance with DATA_WIDTH=4 exercises the saturation of the
//   retired-instruction counter. It is driven from the low bits of the same
//   stimulus.
// -----------------------------------------------------------------------------
module tb_mem_wb_reg;

  // ---------------- clock / reset ----------------
  logic        i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_reset, i_enable, i_stall, i_flush, i_valid;
  logic [31:0] i_address, i_dataread;
  logic        i_memtoreg, i_regwrite, i_halt;
  logic [4:0]  i_rd;

  logic [31:0] o_address, o_dataread, o_retired;
  logic        o_memtoreg, o_regwrite, o_valid, o_halt;
  logic [4:0]  o_rd;

  logic [3:0]  s_address, s_dataread, s_retired;
  logic        s_memtoreg, s_regwrite, s_valid, s_halt;
  logic [4:0]  s_rd;

  mem_wb_reg dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
    .i_flush(i_flush), .i_valid(i_valid), .i_address(i_address),
    .i_dataread(i_dataread), .i_memtoreg(i_memtoreg), .i_regwrite(i_regwrite),
    .i_rd(i_rd), .i_halt(i_halt), .o_address(o_address),
    .o_dataread(o_dataread), .o_memtoreg(o_memtoreg), .o_regwrite(o_regwrite),
    .o_rd(o_rd), .o_valid(o_valid), .o_halt(o_halt), .o_retired(o_retired)
  );

  mem_wb_reg #(.DATA_WIDTH(4), .REG_ADDR_WIDTH(5)) dut_small (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
    .i_flush(i_flush), .i_valid(i_valid), .i_address(i_address[3:0]),
    .i_dataread(i_dataread[3:0]), .i_memtoreg(i_memtoreg),
    .i_regwrite(i_regwrite), .i_rd(i_rd), .i_halt(i_halt),
    .o_address(s_address), .o_dataread(s_dataread), .o_memtoreg(s_memtoreg),
    .o_regwrite(s_regwrite), .o_rd(s_rd), .o_valid(s_valid), .o_halt(s_halt),
    .o_retired(s_retired)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_address, m_dataread;
  logic        m_memtoreg, m_regwrite, m_valid, m_halt;
  logic [4:0]  m_rd;
  longint      m_retired;     // unbounded count; each width clamps it
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] sat(input longint n, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (n > mx) ? 32'(mx) : 32'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Work out the effect of the current inputs on the WB slot, then clock.
  task automatic tick();
    logic [31:0] n_address, n_dataread;
    logic        n_memtoreg, n_regwrite, n_valid, n_halt;
    logic [4:0]  n_rd;
    longint      n_retired;
    n_address = m_address; n_dataread = m_dataread; n_memtoreg = m_memtoreg;
    n_regwrite = m_regwrite; n_valid = m_valid; n_halt = m_halt;
    n_rd = m_rd; n_retired = m_retired;
    if (!i_reset) begin
      n_address = 0; n_dataread = 0; n_memtoreg = 0; n_regwrite = 0;
      n_valid = 0; n_halt = 0; n_rd = 0; n_retired = 0;
    end else if (i_enable && i_flush) begin
      n_valid = 0; n_regwrite = 0; n_memtoreg = 0;
    end else if (m_halt) begin
      n_regwrite = 0;
    end else if (i_enable && !i_stall) begin
      n_address = i_address; n_dataread = i_dataread; n_memtoreg = i_memtoreg;
      n_rd = i_rd; n_valid = i_valid;
      n_regwrite = i_regwrite && i_valid && (i_rd != 0);
      if (i_valid) n_retired = m_retired + 1;
      if (i_valid && i_halt) n_halt = 1;
    end
    @(posedge i_clk);
    #1;
    m_address = n_address; m_dataread = n_dataread; m_memtoreg = n_memtoreg;
    m_regwrite = n_regwrite; m_valid = n_valid; m_halt = n_halt;
    m_rd = n_rd; m_retired = n_retired;
  endtask

  task automatic check_all();
    chk("address",    o_address, m_address);
    chk("dataread",   o_dataread, m_dataread);
    chk("memtoreg",   32'(o_memtoreg), 32'(m_memtoreg));
    chk("regwrite",   32'(o_regwrite), 32'(m_regwrite));
    chk("rd",         32'(o_rd), 32'(m_rd));
    chk("valid",      32'(o_valid), 32'(m_valid));
    chk("halt",       32'(o_halt), 32'(m_halt));
    chk("retired",    o_retired, sat(m_retired, 32));
    chk("s_retired",  32'(s_retired), sat(m_retired, 4));
    chk("s_address",  32'(s_address), 32'(m_address[3:0]));
    chk("s_regwrite", 32'(s_regwrite), 32'(m_regwrite));
    chk("s_halt",     32'(s_halt), 32'(m_halt));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ctl(input logic rst, input logic en, input logic st, input logic fl);
    i_reset = rst; i_enable = en; i_stall = st; i_flush = fl;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rd, input logic rw, input logic h);
    i_valid = v; i_rd = rd; i_regwrite = rw; i_halt = h;
    i_address = $urandom; i_dataread = $urandom; i_memtoreg = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    set_ctl(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    set_instr(1'b1, 5'($urandom), 1'b1, 1'($urandom_range(0, 1)));
    tick(); check_all();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    m_address = 'x; m_dataread = 'x; m_memtoreg = 'x; m_regwrite = 'x;
    m_valid = 'x; m_halt = 'x; m_rd = 'x; m_retired = 0;

    // Reset value of every output.
    do_reset();
    do_reset();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_retired", o_retired, 32'd0);

    // Pass-through of a single instruction.
    set_ctl(1, 1, 0, 0);
    set_instr(1, 5'd5, 1, 0);
    i_address = 32'h0000_1234; i_dataread = 32'hDEAD_BEEF; i_memtoreg = 1;
    tick(); check_all();
    chk("pt_address", o_address, 32'h0000_1234);
    chk("pt_dataread", o_dataread, 32'hDEAD_BEEF);
    chk("pt_rd", 32'(o_rd), 32'd5);
    chk("pt_regwrite", 32'(o_regwrite), 32'd1);
    chk("pt_memtoreg", 32'(o_memtoreg), 32'd1);
    chk("pt_retired", o_retired, 32'd1);

    // A write to r0 is suppressed but the instruction still retires.
    set_instr(1, 5'd0, 1, 0);
    tick(); check_all();
    chk("r0_regwrite", 32'(o_regwrite), 32'd0);
    chk("r0_valid", 32'(o_valid), 32'd1);
    chk("r0_retired", o_retired, 32'd2);

    // A bubble is captured but does not retire.
    set_instr(0, 5'd9, 1, 0);
    tick(); check_all();
    chk("bub_valid", 32'(o_valid), 32'd0);
    chk("bub_retired", o_retired, 32'd2);

    // Capture rd=7, stall for 3 cycles, then flush together with the stall.
    set_instr(1, 5'd7, 1, 0);
    tick(); check_all();
    set_ctl(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 5'($urandom), 1, 0);
      tick(); check_all();
      chk("stall_rd", 32'(o_rd), 32'd7);
      chk("stall_retired", o_retired, 32'd3);
    end
    set_ctl(1, 1, 1, 1);
    tick(); check_all();
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_regwrite", 32'(o_regwrite), 32'd0);
    chk("flush_rd", 32'(o_rd), 32'd7);

    // A HALT arriving together with a flush is not latched.
    set_ctl(1, 1, 0, 1);
    set_instr(1, 5'd4, 1, 1);
    tick(); check_all();
    chk("flush_halt", 32'(o_halt), 32'd0);

    // Valid HALT followed by 4 valid instructions, then reset.
    do_reset();
    set_ctl(1, 1, 0, 0);
    set_instr(1, 5'd3, 1, 1);
    tick(); check_all();
    chk("halt_set", 32'(o_halt), 32'd1);
    chk("halt_retired", o_retired, 32'd1);
    for (int i = 0; i < 4; i++) begin
      set_instr(1, 5'd6, 1, 0);
      tick(); check_all();
      chk("halted_regwrite", 32'(o_regwrite), 32'd0);
      chk("halted_retired", o_retired, 32'd1);
      chk("halted_rd", 32'(o_rd), 32'd3);
    end
    do_reset();
    chk("halt_clear", 32'(o_halt), 32'd0);
    chk("halt_retired_clear", o_retired, 32'd0);

    // Debug step: enable pulsed for one cycle out of every four.
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 4; c++) begin
        set_ctl(1, (c == 0), 0, 0);
        set_instr(1, 5'($urandom), 1, 0);
        tick(); check_all();
      end
      chk("step_retired", o_retired, 32'(p + 1));
    end

    // Saturation: 20 valid advances; the 4-bit counter must stop at 15.
    do_reset();
    set_ctl(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      set_instr(1, 5'($urandom), 1, 0);
      tick(); check_all();
    end
    chk("sat_small", 32'(s_retired), 32'd15);
    chk("sat_big", o_retired, 32'd20);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_ctl(($urandom_range(0, 29) != 0), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      set_instr(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
      tick(); check_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_reg.md
MEM_WB_REG -- requirements
Module: MEM_WB_REG

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the datapath width.
REQ-002 The block SHALL have parameter REG_ADDR_WIDTH, default 5, giving the register-file index width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port i_clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port i_reset  input  1  synchronous active-low reset.
REQ-006 The block SHALL have port i_enable  input  1  pipeline run/step enable (debug unit).
REQ-007 The block SHALL have port i_stall  input  1  hold current contents.
REQ-008 The block SHALL have port i_flush  input  1  squash current contents.
REQ-009 The block SHALL have port i_valid  input  1  MEM-stage slot holds a real instruction.
REQ-010 The block SHALL have port i_address  input  DATA_WIDTH  ALU result / memory address from MEM.
REQ-011 The block SHALL have port i_dataread  input  DATA_WIDTH  data-memory read word.
REQ-012 The block SHALL have port i_memtoreg  input  1  WB select flag, passed through unchanged.
REQ-013 The block SHALL have port i_regwrite  input  1  instruction writes the register file.
REQ-014 The block SHALL have port i_rd  input  REG_ADDR_WIDTH  destination register index.
REQ-015 The block SHALL have port i_halt  input  1  instruction is HALT.
REQ-016 The block SHALL have outputs o_address, o_dataread (DATA_WIDTH), o_memtoreg (1) and o_rd (REG_ADDR_WIDTH), each holding the registered copy of its input, feeding the WB select mux.
REQ-017 The block SHALL have output o_regwrite  1  qualified register-file write enable.
REQ-018 The block SHALL have outputs o_valid (1, WB slot valid), o_halt (1, sticky halt flag) and o_retired (DATA_WIDTH, retired-instruction count).

Function
REQ-019 All outputs SHALL be registered, with 1-cycle latency from capture to output.
REQ-020 advance SHALL be defined as i_enable & ~i_stall & ~o_halt & ~i_flush.
REQ-021 Priority SHALL be reset > flush > halted > stall/disabled hold > advance.
REQ-022 On advance, all data/control outputs SHALL load their inputs, and o_valid SHALL load i_valid.
REQ-023 On advance, o_regwrite SHALL load i_regwrite & i_valid & (i_rd != 0), so writes to r0 are suppressed.
REQ-024 On i_enable & i_flush (stall ignored), o_valid, o_regwrite and o_memtoreg SHALL clear to 0, o_address, o_dataread and o_rd SHALL hold, and o_retired SHALL not increment.
REQ-025 On stall or i_enable=0 (no flush), all outputs SHALL hold their value, with no duplicate write and no count.
REQ-026 On advance with i_valid & i_halt, o_halt SHALL set to 1 in the same edge that captures the instruction.
REQ-027 o_halt SHALL remain 1 until reset, and while o_halt=1 no further capture SHALL occur, the last captured contents SHALL hold, and o_regwrite SHALL be forced to 0 from the cycle after the halt capture.
REQ-028 On advance with i_valid=1 (halt included), o_retired SHALL increment by 1.
REQ-029 o_retired SHALL saturate at all-ones and SHALL not wrap.
REQ-030 On advance with i_valid=0, the bubble SHALL be captured: o_valid=0, o_regwrite=0, and no count.
REQ-031 When flush and stall are asserted together, flush SHALL win.
REQ-032 When flush and halt are asserted together, flush SHALL win: the halt is not latched.

Reset
REQ-033 When i_reset=0 at a rising edge, all outputs SHALL go to 0 (o_valid, o_regwrite, o_memtoreg, o_halt, o_rd, o_address, o_dataread, o_retired) regardless of the other inputs.
REQ-034 A reset asserted mid-stall or mid-halt SHALL clear the sticky halt and the count, and capture SHALL resume on the first edge with i_reset=1 and advance true.

Verification
REQ-035 The bench SHALL cover pass-through: reset, then i_valid=1, i_regwrite=1, i_rd=5, i_address=0x0000_1234, i_dataread=0xDEAD_BEEF, i_memtoreg=1 -> next cycle the outputs equal these values, o_regwrite=1, o_retired=1.
REQ-036 The bench SHALL cover r0 suppression: i_rd=0, i_regwrite=1, i_valid=1 -> o_regwrite=0, o_valid=1, o_retired increments.
REQ-037 The bench SHALL cover stall then flush: capture rd=7, then stall 3 cycles -> outputs unchanged and o_retired unchanged; then assert flush with stall -> o_valid=0, o_regwrite=0, o_rd=7.
REQ-038 The bench SHALL cover halt: a valid HALT followed by 4 valid instructions -> o_halt=1 after the HALT edge, o_retired counts the HALT only, o_regwrite=0 thereafter; reset then clears o_halt and o_retired to 0.
REQ-039 The bench SHALL cover saturation: preload o_retired to 0xFFFF_FFFE via 2 advances after forcing, or a reduced DATA_WIDTH=4 build with 16 valid advances -> the count stops at all-ones.
REQ-040 The bench SHALL cover debug step: i_enable pulsed 1 cycle every 4 with valid input each cycle -> exactly one capture per pulse, with o_retired equal to the pulse count.
